// File: rtl/cache_pkg.sv
// Shared definitions for the cache line memory controller.
// Holds the FSM state encoding, the default line geometry and the helpers
// that derive word/line offset widths from a words-per-line count.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int BYTE_OFF_BITS          = 2;
    localparam int DEFAULT_WORDS_PER_LINE = 4;
    localparam int WORD_OFF_BITS          = $clog2(DEFAULT_WORDS_PER_LINE);
    localparam int LINE_OFF_BITS          = WORD_OFF_BITS + BYTE_OFF_BITS;

    // Bits needed to index a word inside a line.
    function automatic int word_off_bits(input int words);
        return $clog2(words);
    endfunction

    // Byte offset bits covering a whole line.
    function automatic int line_off_bits(input int words);
        return $clog2(words) + BYTE_OFF_BITS;
    endfunction

    // Clear the in-line offset bits of a byte address.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int off);
        return (addr >> off) << off;
    endfunction

endpackage

// File: rtl/cache_mem_ctrl.sv
// Cache line transfer controller: optionally writes back a dirty victim
// line, then refills a line, one 32-bit word at a time against a simple
// cs/we/ack RAM.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req, req_wb              transaction request / victim is dirty
//   wb_addr, fill_addr       victim and refill line addresses
//   wb_line                  victim data (word 0 in [31:0])
//   busy, done               not idle / one-cycle completion pulse
//   fill_line                refilled line (word 0 in [31:0])
//   mem_cs, mem_we           RAM chip select / write enable
//   mem_addr, mem_din        RAM byte address / write data
//   mem_dout, mem_ack        RAM read data / completion strobe
module cache_mem_ctrl
    import cache_pkg::*;
#(
    parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req,
    input  logic                          req_wb,
    input  logic [31:0]                   wb_addr,
    input  logic [31:0]                   fill_addr,
    input  logic [32*WORDS_PER_LINE-1:0]  wb_line,
    output logic                          busy,
    output logic                          done,
    output logic [32*WORDS_PER_LINE-1:0]  fill_line,
    output logic                          mem_cs,
    output logic                          mem_we,
    output logic [31:0]                   mem_addr,
    output logic [31:0]                   mem_din,
    input  logic [31:0]                   mem_dout,
    input  logic                          mem_ack
);

    localparam int IDX_W    = word_off_bits(WORDS_PER_LINE);
    localparam int LINE_OFF = line_off_bits(WORDS_PER_LINE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

    state_t                         state_r, state_n;
    logic [IDX_W-1:0]               idx_r, idx_n;
    logic [31:0]                    wb_base_r;
    logic [31:0]                    fill_base_r;
    logic [32*WORDS_PER_LINE-1:0]   wb_line_r;
    logic [32*WORDS_PER_LINE-1:0]   fill_line_r;
    logic [31:0]                    word_off_s;

    assign word_off_s = 32'({idx_r, 2'b00});
    assign fill_line  = fill_line_r;

    // State and word index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
        end
    end

    // Next-state and word index sequencing; each ack retires one word.
    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    state_n = req_wb ? ST_WB : ST_FILL;
                    idx_n   = '0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WB, ST_FILL: begin
                if (mem_ack) begin
                    if (idx_r == LAST_IDX) begin
                        idx_n   = '0;
                        state_n = (state_r == ST_WB) ? ST_FILL : ST_DONE;
                    end else begin
                        idx_n   = idx_r + 1'b1;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: begin
                state_n = ST_IDLE;
                idx_n   = '0;
            end
        endcase
    end

    // Request latch on accept and refill data capture on each read ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_base_r   <= 32'h0;
            fill_base_r <= 32'h0;
            wb_line_r   <= '0;
            fill_line_r <= '0;
        end else begin
            if (state_r == ST_IDLE && req) begin
                wb_base_r   <= line_base(wb_addr, LINE_OFF);
                fill_base_r <= line_base(fill_addr, LINE_OFF);
                wb_line_r   <= wb_line;
            end
            if (state_r == ST_FILL && mem_ack) begin
                fill_line_r[{idx_r, 5'd0} +: 32] <= mem_dout;
            end
        end
    end

    // RAM and status outputs decoded from registered state; cs drops in
    // the ack cycle so the RAM sees an idle cycle between words.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        mem_cs   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = 32'h0;
        mem_din  = 32'h0;
        case (state_r)
            ST_IDLE: busy = 1'b0;
            ST_WB: begin
                busy     = 1'b1;
                mem_cs   = ~mem_ack;
                mem_we   = 1'b1;
                mem_addr = wb_base_r + word_off_s;
                mem_din  = wb_line_r[{idx_r, 5'd0} +: 32];
            end
            ST_FILL: begin
                busy     = 1'b1;
                mem_cs   = ~mem_ack;
                mem_addr = fill_base_r + word_off_s;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed self-checking bench for cache_mem_ctrl with a four-cycle RAM model.
module tb_cache_mem_ctrl;

    logic         clk = 1'b0;
    logic         rst, req, req_wb;
    logic [31:0]  wb_addr, fill_addr;
    logic [127:0] wb_line;
    logic         busy, done;
    logic [127:0] fill_line;
    logic         mem_cs, mem_we;
    logic [31:0]  mem_addr, mem_din, mem_dout;
    logic         mem_ack, ram_ack, spur_ack;

    int checks = 0;
    int errors = 0;
    int proto_err = 0;

    logic [31:0] wmem [0:127];
    logic        wval [0:127];
    logic [31:0] dout_r;
    int          ram_cnt;

    logic [31:0] log_addr [0:15];
    logic [31:0] log_din  [0:15];
    logic [15:0] log_we;

    cache_mem_ctrl #(.WORDS_PER_LINE(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wb(req_wb),
        .wb_addr(wb_addr), .fill_addr(fill_addr), .wb_line(wb_line),
        .busy(busy), .done(done), .fill_line(fill_line),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    assign mem_ack  = ram_ack | spur_ack;
    assign mem_dout = dout_r;

    // Preloaded RAM contents for locations never written.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a >= 32'h40 && a < 32'h50) return 32'h11111111 * (32'(a[3:2]) + 32'd1);
        if (a >= 32'h100 && a < 32'h110) return 32'h5A5A0000 | 32'(a[3:2]);
        return 32'h0;
    endfunction

    // RAM: acks the fifth cycle after cs first rises, performing the access then.
    always @(posedge clk) begin
        if (rst) begin
            ram_ack <= 1'b0;
            ram_cnt <= 0;
            dout_r  <= 32'h0;
            for (int i = 0; i < 128; i++) wval[i] <= 1'b0;
        end else if (ram_ack) begin
            ram_ack <= 1'b0;
            ram_cnt <= 0;
        end else if (mem_cs) begin
            if (ram_cnt == 3) begin
                ram_ack <= 1'b1;
                ram_cnt <= 0;
                if (mem_we) begin
                    wmem[mem_addr[8:2]] <= mem_din;
                    wval[mem_addr[8:2]] <= 1'b1;
                end else begin
                    dout_r <= (wval[mem_addr[8:2]] === 1'b1) ? wmem[mem_addr[8:2]] : init_word(mem_addr);
                end
            end else begin
                ram_cnt <= ram_cnt + 1;
            end
        end else begin
            ram_cnt <= 0;
        end
    end

    // Protocol watch: cs never high with ack, no unknown address or read data.
    always @(negedge clk) begin
        if ((mem_ack === 1'b1 && mem_cs !== 1'b0) ||
            (mem_cs === 1'b1 && (^mem_addr === 1'bx || mem_we === 1'bx)) ||
            (ram_ack === 1'b1 && busy === 1'b1 && mem_we === 1'b0 && ^mem_dout === 1'bx))
            proto_err <= proto_err + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and log every ack until done (cycle 0 = accept).
    task automatic run_txn(input logic wb, input logic [31:0] wa, input logic [31:0] fa,
                           input logic [127:0] wl, output int done_cyc, output int nacks);
        req = 1'b1; req_wb = wb; wb_addr = wa; fill_addr = fa; wb_line = wl;
        tick();
        req = 1'b0;
        done_cyc = -1;
        nacks = 0;
        log_we = 16'h0;
        for (int c = 1; c <= 100; c++) begin
            if (ram_ack === 1'b1 && nacks < 16) begin
                log_addr[nacks] = mem_addr;
                log_din[nacks]  = mem_din;
                log_we[nacks]   = mem_we;
                nacks++;
            end
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int dc, na, cnt, idle_cnt, done_cnt;
        logic [127:0] wl;
        rst = 1'b1; req = 1'b0; req_wb = 1'b0; spur_ack = 1'b0;
        wb_addr = 32'h0; fill_addr = 32'h0; wb_line = 128'h0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs", mem_cs, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_din", mem_din, 0);
        chk("rst_fill_line", fill_line, 0);
        rst = 1'b0;
        tick();

        // Fill only, unaligned request address.
        run_txn(1'b0, 32'h0, 32'h48, 128'h0, dc, na);
        chk("fill_done_cycle", dc, 21);
        chk("fill_nacks", na, 4);
        for (int i = 0; i < 4; i++) chk("fill_addr", log_addr[i], 32'h40 + 32'(4 * i));
        chk("fill_we", log_we, 16'h0000);
        chk("fill_line", fill_line, 128'h44444444_33333333_22222222_11111111);
        tick();
        chk("fill_done_pulse", done, 0);
        chk("fill_idle", busy, 0);

        // Write-back then fill.
        wl = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        run_txn(1'b1, 32'h80, 32'h100, wl, dc, na);
        chk("wb_done_cycle", dc, 41);
        chk("wb_nacks", na, 8);
        chk("wb_we", log_we, 16'h000F);
        for (int i = 0; i < 4; i++) begin
            chk("wb_addr", log_addr[i], 32'h80 + 32'(4 * i));
            chk("wb_din", log_din[i], wl[32*i +: 32]);
            chk("wbfill_addr", log_addr[i+4], 32'h100 + 32'(4 * i));
        end
        chk("wb_mem80", wmem[32], 32'hAAAAAAAA);
        chk("wb_mem8c", wmem[35], 32'hDDDDDDDD);
        chk("wbfill_line", fill_line, 128'h5A5A0003_5A5A0002_5A5A0001_5A5A0000);
        tick();

        // Reset after the second fill ack.
        req = 1'b1; req_wb = 1'b0; fill_addr = 32'h40;
        tick();
        req = 1'b0;
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            if (ram_ack === 1'b1) cnt++;
            if (cnt == 2) break;
            tick();
        end
        chk("abort_acks_seen", cnt, 2);
        tick();
        chk("abort_pre_cs", mem_cs, 1);
        rst = 1'b1;
        #1;
        chk("abort_cs", mem_cs, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_fill_line", fill_line, 0);
        tick();
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) done_cnt++;
            tick();
        end
        chk("abort_no_done", done_cnt, 0);
        run_txn(1'b0, 32'h0, 32'h40, 128'h0, dc, na);
        chk("refill_done_cycle", dc, 21);
        chk("refill_line", fill_line, 128'h44444444_33333333_22222222_11111111);
        tick();

        // req held high for 50 cycles: one transaction per IDLE visit.
        req = 1'b1; req_wb = 1'b0; fill_addr = 32'h40;
        idle_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (busy === 1'b0) idle_cnt++;
            if (done === 1'b1) done_cnt++;
        end
        req = 1'b0;
        chk("held_done_count", done_cnt, 2);
        chk("held_idle_count", idle_cnt, 2);
        for (int c = 0; c < 100; c++) begin
            if (busy === 1'b0) break;
            tick();
        end
        chk("held_drain_idle", busy, 0);
        tick();
        chk("held_stays_idle", busy, 0);

        // Spurious ack in IDLE.
        spur_ack = 1'b1;
        #1;
        chk("spur_cs", mem_cs, 0);
        tick();
        spur_ack = 1'b0;
        chk("spur_busy", busy, 0);
        chk("spur_fill_line", fill_line, 128'h44444444_33333333_22222222_11111111);
        tick();
        chk("spur_done", done, 0);
        chk("spur_busy2", busy, 0);

        chk("protocol", proto_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
